fft_dit_ctrl: RTL

- Sequencing controller for one radix-2 DIT FFT frame of N=2^LOG2N complex points, driving a single shared combinational butterfly unit.
- Butterfly contract: y0 = a + b·W, y1 = a − b·W; 16-bit two's-complement, truncated.
- Per frame: accepts N samples on a valid/ready stream into an internal in-place register bank, stored in bit-reversed order. Runs LOG2N stages at one butterfly per cycle, then streams N results out in natural order.
- Twiddle values come from an external ROM addressed by bf_tw_idx. The top level wires the ROM output to the butterfly tw inputs.

---
 rtl/fft_dit_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fft_dit_ctrl.sv
// Sequencer for one in-place radix-2 DIT FFT frame: bit-reversed load, LOG2N butterfly
// stages on a shared external butterfly, then natural-order unload.
module fft_dit_ctrl #(
   parameter int LOG2N = 3,
   parameter int W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_re,
   input  logic [W-1:0]     in_im,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_re,
   output logic [W-1:0]     out_im,
   output logic             out_last,
   output logic             busy,
   output logic [W-1:0]     bf_a_re,
   output logic [W-1:0]     bf_a_im,
   output logic [W-1:0]     bf_b_re,
   output logic [W-1:0]     bf_b_im,
   output logic [LOG2N-2:0] bf_tw_idx,
   input  logic [W-1:0]     bf_y0_re,
   input  logic [W-1:0]     bf_y0_im,
   input  logic [W-1:0]     bf_y1_re,
   input  logic [W-1:0]     bf_y1_im
);

   localparam int N  = 1 << LOG2N;
   localparam int SW = $clog2(LOG2N);
   localparam int TW = LOG2N - 1;
   localparam logic [LOG2N-1:0] ONE_IDX    = LOG2N'(1);
   localparam logic [LOG2N-1:0] LAST_IDX   = LOG2N'(N - 1);
   localparam logic [TW-1:0]    LAST_BF    = {TW{1'b1}};
   localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);

   typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_e;

   state_e           state_q, state_d;
   logic [LOG2N-1:0] inCnt_q, inCnt_d;
   logic [LOG2N-1:0] outCnt_q, outCnt_d;
   logic [SW-1:0]    stage_q, stage_d;
   logic [TW-1:0]    bfly_q, bfly_d;
   logic [W-1:0]     bankRe_q [N];
   logic [W-1:0]     bankIm_q [N];

   logic [LOG2N-1:0] loadIdx, topIdx, botIdx, kExt, hMask;
   logic [SW-1:0]    twShift;
   logic [TW-1:0]    twIdx;
   logic             inFire, outFire;

   // Butterfly addressing: top keeps the low s bits of k and opens a zero at bit s.
   always_comb begin
      loadIdx = '0;
      for (int i = 0; i < LOG2N; i++) loadIdx[i] = inCnt_q[LOG2N-1-i];
      kExt    = {1'b0, bfly_q};
      hMask   = (ONE_IDX << stage_q) - ONE_IDX;
      topIdx  = ((kExt & ~hMask) << 1) | (kExt & hMask);
      botIdx  = topIdx | (ONE_IDX << stage_q);
      twShift = LAST_STAGE - stage_q;
      twIdx   = TW'(kExt & hMask) << twShift;
   end

   assign inFire  = (state_q == LOAD) && in_valid;
   assign outFire = (state_q == UNLOAD) && out_ready;

   always_comb begin
      state_d  = state_q;
      inCnt_d  = inCnt_q;
      outCnt_d = outCnt_q;
      stage_d  = stage_q;
      bfly_d   = bfly_q;
      case (state_q)
         LOAD: begin
            if (inFire) begin
               inCnt_d = inCnt_q + ONE_IDX;
               if (inCnt_q == LAST_IDX) begin
                  state_d = COMPUTE;
                  stage_d = '0;
                  bfly_d  = '0;
               end
            end
         end
         COMPUTE: begin
            bfly_d = bfly_q + TW'(1);
            if (bfly_q == LAST_BF) begin
               stage_d = stage_q + SW'(1);
               if (stage_q == LAST_STAGE) begin
                  state_d = UNLOAD;
                  stage_d = '0;
               end
            end
         end
         UNLOAD: begin
            if (outFire) begin
               outCnt_d = outCnt_q + ONE_IDX;
               if (outCnt_q == LAST_IDX) state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // Outputs are forced quiet while reset is held, regardless of the registered state.
   always_comb begin
      in_ready  = !rst && (state_q == LOAD);
      out_valid = !rst && (state_q == UNLOAD);
      busy      = !rst && (state_q != LOAD);
      out_last  = out_valid && (outCnt_q == LAST_IDX);
      out_re    = bankRe_q[outCnt_q];
      out_im    = bankIm_q[outCnt_q];
      bf_a_re   = '0;
      bf_a_im   = '0;
      bf_b_re   = '0;
      bf_b_im   = '0;
      bf_tw_idx = '0;
      if (!rst && (state_q == COMPUTE)) begin
         bf_a_re   = bankRe_q[topIdx];
         bf_a_im   = bankIm_q[topIdx];
         bf_b_re   = bankRe_q[botIdx];
         bf_b_im   = bankIm_q[botIdx];
         bf_tw_idx = twIdx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LOAD;
         inCnt_q  <= '0;
         outCnt_q <= '0;
         stage_q  <= '0;
         bfly_q   <= '0;
      end else begin
         state_q  <= state_d;
         inCnt_q  <= inCnt_d;
         outCnt_q <= outCnt_d;
         stage_q  <= stage_d;
         bfly_q   <= bfly_d;
      end
   end

   // In-place bank: top and bottom indices never collide within a stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            bankRe_q[i] <= '0;
            bankIm_q[i] <= '0;
         end
      end else if (inFire) begin
         bankRe_q[loadIdx] <= in_re;
         bankIm_q[loadIdx] <= in_im;
      end else if (state_q == COMPUTE) begin
         bankRe_q[topIdx] <= bf_y0_re;
         bankIm_q[topIdx] <= bf_y0_im;
         bankRe_q[botIdx] <= bf_y1_re;
         bankIm_q[botIdx] <= bf_y1_im;
      end
   end

endmodule
